// File: rtl/ram8_access_ctrl_pkg.sv
// Shared definitions for the 8-word register RAM access controller:
// request opcodes, controller state encoding and small decode helpers.
package ram8_access_ctrl_pkg;

  localparam int unsigned WIDTH_DEF = 16;
  localparam int unsigned AW_DEF    = 3;

  typedef enum logic [1:0] {
    OP_READ  = 2'b00,
    OP_WRITE = 2'b01,
    OP_CLEAR = 2'b10,
    OP_FILL  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WRITE = 3'd2,
    ST_SWEEP = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

  // CLEAR and FILL both walk the whole array; only the written value differs.
  function automatic logic is_sweep_op(input op_e op);
    return (op == OP_CLEAR) || (op == OP_FILL);
  endfunction

  function automatic state_e op_to_state(input op_e op);
    state_e st;
    case (op)
      OP_READ:  st = ST_READ;
      OP_WRITE: st = ST_WRITE;
      default:  st = ST_SWEEP;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/ram8_access_ctrl.sv
// Request/response front end for the 8x16 register RAM: serialises single-word
// read/write and whole-array clear/fill sweeps behind a valid/ready request port.
module ram8_access_ctrl
  import ram8_access_ctrl_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [AW-1:0]    req_addr,
  input  logic [WIDTH-1:0] req_data,
  output logic             rsp_valid,
  output logic [WIDTH-1:0] rsp_data,
  output logic             busy,
  output logic [WIDTH-1:0] ram_in,
  output logic             ram_load,
  output logic [AW-1:0]    ram_address,
  input  logic [WIDTH-1:0] ram_out,
  output logic [2:0]       dbg_state
);

  // Handshake: a request is accepted on a rising edge where req_valid and
  // req_ready are both high and reset is low. req_ready is high only in IDLE;
  // requests presented at other times are ignored, never queued. rsp_valid is
  // a single-cycle pulse with no backpressure; rsp_data holds until the next one.

  localparam logic [AW-1:0] LAST_ADDR = {AW{1'b1}};

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic [AW-1:0]    ram_addr_q, ram_addr_d;

  logic             accept;
  logic             sweep_last;
  logic [WIDTH-1:0] sweep_val;

  assign accept     = req_valid && (state_q == ST_IDLE);
  assign sweep_last = (cnt_q == LAST_ADDR);
  assign sweep_val  = (op_q == OP_CLEAR) ? '0 : data_q;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = op_to_state(op_e'(req_op));
        end
      end
      ST_READ:  state_d = ST_RESP;
      ST_WRITE: state_d = ST_RESP;
      ST_SWEEP: begin
        if (sweep_last) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    busy        = (state_q != ST_IDLE);
    rsp_valid   = (state_q == ST_RESP);
    rsp_data    = rsp_data_q;
    dbg_state   = state_q;
    ram_address = ram_addr_q;
    ram_in      = '0;
    ram_load    = 1'b0;
    case (state_q)
      ST_READ: begin
        ram_address = addr_q;
      end
      ST_WRITE: begin
        ram_address = addr_q;
        ram_in      = data_q;
        ram_load    = !reset;
      end
      ST_SWEEP: begin
        ram_address = cnt_q;
        ram_in      = sweep_val;
        ram_load    = !reset;
      end
      default: begin
        ram_address = ram_addr_q;
      end
    endcase
  end

  // Request latch, sweep counter, response register and address hold
  always_comb begin
    op_d       = op_q;
    addr_d     = addr_q;
    data_d     = data_q;
    cnt_d      = cnt_q;
    rsp_data_d = rsp_data_q;
    ram_addr_d = ram_address;
    if (accept) begin
      op_d   = op_e'(req_op);
      addr_d = req_addr;
      data_d = req_data;
      cnt_d  = '0;
    end
    case (state_q)
      ST_READ:  rsp_data_d = ram_out;
      ST_WRITE: rsp_data_d = data_q;
      ST_SWEEP: begin
        if (sweep_last) begin
          rsp_data_d = sweep_val;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      op_q       <= OP_READ;
      addr_q     <= '0;
      data_q     <= '0;
      cnt_q      <= '0;
      rsp_data_q <= '0;
      ram_addr_q <= '0;
    end else begin
      op_q       <= op_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      cnt_q      <= cnt_d;
      rsp_data_q <= rsp_data_d;
      ram_addr_q <= ram_addr_d;
    end
  end

endmodule
